// File: rtl/i2s_rx.sv
// I2S record-path receiver: master clocks toward the codec ADC, deserialises left/right pairs.
// Optional macro I2S_RX_FIFO_EN replaces the single output register with a 4-entry pair FIFO.
module i2s_rx #(
    parameter int unsigned BPS       = 24,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned BCLK_HALF = 24,
    parameter int unsigned MCLK_HALF = 3
) (
    input  logic           in_clk,
    input  logic           in_rst_n,
    input  logic           in_en,
    input  logic           in_RECDAT,
    output logic           out_MCLK,
    output logic           out_BCLK,
    output logic           out_RECLRC,
    output logic [BPS-1:0] out_left,
    output logic [BPS-1:0] out_right,
    output logic           out_valid,
    input  logic           in_ready,
    output logic           out_overrun
);
    localparam int unsigned McW  = $clog2(MCLK_HALF + 1);
    localparam int unsigned BcW  = $clog2(BCLK_HALF + 1);
    localparam int unsigned IdxW = $clog2(SLOT_BITS + 1);

    typedef enum logic {StIdle, StRun} state_e;
    state_e state_q, state_d;

    logic [McW-1:0]  mclk_cnt_q, mclk_cnt_d;
    logic [BcW-1:0]  bclk_cnt_q, bclk_cnt_d;
    logic            mclk_q, mclk_d;
    logic            bclk_q, bclk_d;
    logic            lrc_q, lrc_d;
    logic            lrc_pend_q, lrc_pend_d;
    logic [IdxW-1:0] bit_idx_q, bit_idx_d;
    logic [BPS-1:0]  shift_q, shift_d;
    logic [BPS-1:0]  hold_q, hold_d;
    logic            complete_q, complete_d;

    logic running, mclk_tick, bclk_tick, bclk_rise, bclk_fall;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The enabling edge only arms the generators; counting starts on the following edge.
    always_comb begin
        state_d = in_en ? StRun : StIdle;
    end

    assign running   = (state_q == StRun) && in_en;
    assign mclk_tick = running && (mclk_cnt_q == McW'(MCLK_HALF - 1));
    assign bclk_tick = running && (bclk_cnt_q == BcW'(BCLK_HALF - 1));
    assign bclk_rise = bclk_tick && !bclk_q;
    assign bclk_fall = bclk_tick && bclk_q;

    always_comb begin
        mclk_cnt_d = '0;
        bclk_cnt_d = '0;
        mclk_d     = 1'b0;
        bclk_d     = 1'b1;
        lrc_d      = 1'b1;
        lrc_pend_d = 1'b0;
        bit_idx_d  = '0;
        shift_d    = '0;
        hold_d     = hold_q;
        complete_d = 1'b0;
        if (running) begin
            mclk_cnt_d = mclk_tick ? '0 : mclk_cnt_q + McW'(1);
            bclk_cnt_d = bclk_tick ? '0 : bclk_cnt_q + BcW'(1);
            mclk_d     = mclk_q ^ mclk_tick;
            bclk_d     = bclk_q ^ bclk_tick;
            lrc_d      = lrc_q;
            lrc_pend_d = lrc_pend_q;
            bit_idx_d  = bit_idx_q;
            shift_d    = shift_q;
            if (bclk_rise) begin
                if (32'(bit_idx_q) < BPS) begin
                    shift_d = {shift_q[BPS-2:0], in_RECDAT};
                end
                if (bit_idx_q == IdxW'(BPS - 1)) begin
                    if (lrc_q) begin
                        hold_d = shift_d;
                    end else begin
                        complete_d = 1'b1;
                    end
                end
                bit_idx_d  = (bit_idx_q == IdxW'(SLOT_BITS - 1)) ? '0 : bit_idx_q + IdxW'(1);
                lrc_pend_d = (bit_idx_q == IdxW'(SLOT_BITS - 1));
            end
            // Frame clock flips on the fall after the last slot bit was captured.
            if (bclk_fall && lrc_pend_q) begin
                lrc_d      = !lrc_q;
                lrc_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            mclk_cnt_q <= '0;
            bclk_cnt_q <= '0;
            mclk_q     <= 1'b0;
            bclk_q     <= 1'b1;
            lrc_q      <= 1'b1;
            lrc_pend_q <= 1'b0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            complete_q <= 1'b0;
        end else begin
            mclk_cnt_q <= mclk_cnt_d;
            bclk_cnt_q <= bclk_cnt_d;
            mclk_q     <= mclk_d;
            bclk_q     <= bclk_d;
            lrc_q      <= lrc_d;
            lrc_pend_q <= lrc_pend_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            complete_q <= complete_d;
        end
    end

    assign out_MCLK   = mclk_q;
    assign out_BCLK   = bclk_q;
    assign out_RECLRC = lrc_q;

    logic push, pop, full, overrun_q;
    assign push = complete_q && in_en;
    assign pop  = out_valid && in_ready;

`ifdef I2S_RX_FIFO_EN
    localparam int unsigned Depth = 4;
    logic [BPS-1:0] fifo_l_q [Depth];
    logic [BPS-1:0] fifo_r_q [Depth];
    logic [1:0]     wr_ptr_q, rd_ptr_q;
    logic [2:0]     count_q;
    logic           do_push;

    assign full    = (count_q == 3'd4);
    // When full, the written slot is the head being popped this same edge.
    assign do_push = push && (!full || pop);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                fifo_l_q[i] <= '0;
                fifo_r_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                fifo_l_q[wr_ptr_q] <= hold_q;
                fifo_r_q[wr_ptr_q] <= shift_q;
                wr_ptr_q           <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + 3'(do_push) - 3'(pop);
        end
    end

    assign out_valid = (count_q != 3'd0);
    assign out_left  = fifo_l_q[rd_ptr_q];
    assign out_right = fifo_r_q[rd_ptr_q];
`else
    logic           valid_q;
    logic [BPS-1:0] left_q, right_q;

    assign full = valid_q;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            valid_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else if (push && (!valid_q || pop)) begin
            valid_q <= 1'b1;
            left_q  <= hold_q;
            right_q <= shift_q;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_left  = left_q;
    assign out_right = right_q;
`endif

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            overrun_q <= 1'b0;
        end else if (!in_en) begin
            overrun_q <= 1'b0;
        end else if (push && full && !pop) begin
            overrun_q <= 1'b1;
        end
    end

    assign out_overrun = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: codec model on RECDAT, queue-based reference for pairs.
`timescale 1ns/1ps
module tb_i2s_rx;
    localparam int unsigned BPS = 24;
`ifdef I2S_RX_FIFO_EN
    localparam int Cap = 4;
`else
    localparam int Cap = 1;
`endif
    localparam int FirstPair = 2689;
    localparam int Frame     = 3072;

    logic           in_clk    = 1'b0;
    logic           in_rst_n  = 1'b0;
    logic           in_en     = 1'b0;
    logic           in_RECDAT = 1'b0;
    logic           in_ready  = 1'b0;
    logic           out_MCLK, out_BCLK, out_RECLRC, out_valid, out_overrun;
    logic [BPS-1:0] out_left, out_right;

    i2s_rx dut (
        .in_clk     (in_clk),
        .in_rst_n   (in_rst_n),
        .in_en      (in_en),
        .in_RECDAT  (in_RECDAT),
        .out_MCLK   (out_MCLK),
        .out_BCLK   (out_BCLK),
        .out_RECLRC (out_RECLRC),
        .out_left   (out_left),
        .out_right  (out_right),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .out_overrun(out_overrun)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    pair_t       q[$];
    logic [23:0] fl[8];
    logic [23:0] fr[8];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic randomize_frames();
        for (int i = 0; i < 8; i++) begin
            fl[i] = 24'($urandom);
            fr[i] = 24'($urandom);
        end
    endtask

    // Bit driven after fall m: 64 bits per frame, left slot first, MSB first, junk padding.
    function automatic logic codec_bit(input int m);
        int          f, pos, b;
        logic [23:0] word;
        f    = m / 64;
        pos  = m % 64;
        b    = pos % 32;
        word = (pos < 32) ? fl[f] : fr[f];
        if (b < 24) return word[23-b];
        return 1'($urandom);
    endfunction

    function automatic bit ready_for(input int k, input int from, input bit rnd);
        if (k < from) return 1'b0;
        return rnd ? 1'($urandom) : 1'b1;
    endfunction

    task automatic do_reset(input string name);
        @(posedge in_clk);
        #1;
        in_rst_n = 1'b0;
        #1;
        check({name, "_rst_bclk"}, 32'(out_BCLK), 32'd1);
        check({name, "_rst_mclk"}, 32'(out_MCLK), 32'd0);
        check({name, "_rst_lrc"}, 32'(out_RECLRC), 32'd1);
        check({name, "_rst_valid"}, 32'(out_valid), 32'd0);
        check({name, "_rst_ovr"}, 32'(out_overrun), 32'd0);
        check({name, "_rst_left"}, 32'(out_left), 32'd0);
        check({name, "_rst_right"}, 32'(out_right), 32'd0);
        in_en    = 1'b0;
        in_ready = 1'b0;
        repeat (3) @(posedge in_clk);
        #1 in_rst_n = 1'b1;
        repeat (2) @(posedge in_clk);
        #1;
    endtask

    task automatic run_phase(input string name, input int pid, input int n_cyc,
                             input int ready_from, input bit rnd, input int abort_at);
        int    bad_clk = 0, bad_valid = 0, bad_data = 0, bad_ov = 0;
        int    ov_edge;
        bit    ready_cur, en_k, ov, popd;
        logic  exp_b, exp_m, exp_l;
        pair_t p;
        ov_edge = FirstPair + Cap * Frame;
        q.delete();
        ov = 1'b0;
        @(posedge in_clk);
        #1;
        in_en     = (abort_at > 0);
        ready_cur = ready_for(0, ready_from, rnd);
        in_ready  = ready_cur;
        in_RECDAT = 1'($urandom);
        for (int k = 0; k < n_cyc; k++) begin
            @(posedge in_clk);
            #1;
            en_k = (k < abort_at);
            popd = (q.size() > 0) && ready_cur;
            if (popd) void'(q.pop_front());
            if (en_k && k >= FirstPair && ((k - FirstPair) % Frame) == 0) begin
                p.l = fl[(k - FirstPair) / Frame];
                p.r = fr[(k - FirstPair) / Frame];
                if (q.size() < Cap) q.push_back(p);
                else ov = 1'b1;
            end
            if (!en_k) ov = 1'b0;
            if (en_k) begin
                exp_b = ((k / 24) % 2) == 0;
                exp_m = ((k / 3) % 2) == 1;
                exp_l = (k < 1560) ? 1'b1 : (((k - 1560) / 1536) % 2) == 1;
            end else begin
                exp_b = 1'b1;
                exp_m = 1'b0;
                exp_l = 1'b1;
            end
            if ({out_BCLK, out_MCLK, out_RECLRC} !== {exp_b, exp_m, exp_l}) bad_clk++;
            if (out_valid !== (q.size() > 0)) bad_valid++;
            if (q.size() > 0 && {out_left, out_right} !== {q[0].l, q[0].r}) bad_data++;
            if (out_overrun !== ov) bad_ov++;

            if (pid == 0) begin
                if (k == 24)   check("A_bclk_fall24", 32'(out_BCLK), 32'd0);
                if (k == 48)   check("A_bclk_rise48", 32'(out_BCLK), 32'd1);
                if (k == 1559) check("A_lrc_1559", 32'(out_RECLRC), 32'd1);
                if (k == 1560) check("A_lrc_1560", 32'(out_RECLRC), 32'd0);
                if (k == 3095) check("A_lrc_3095", 32'(out_RECLRC), 32'd0);
                if (k == 3096) check("A_lrc_3096", 32'(out_RECLRC), 32'd1);
                if (k == 2688) check("A_valid_2688", 32'(out_valid), 32'd0);
                if (k == 2689) begin
                    check("A_valid_2689", 32'(out_valid), 32'd1);
                    check("A_left_2689", 32'(out_left), 32'hA5C3F1);
                    check("A_right_2689", 32'(out_right), 32'h3C0FF0);
                end
                if (k == 2690) check("A_valid_2690", 32'(out_valid), 32'd0);
            end
            if (pid == 1) begin
                if (k == ov_edge - 1) check("B_ovr_before", 32'(out_overrun), 32'd0);
                if (k == ov_edge)     check("B_ovr_set", 32'(out_overrun), 32'd1);
                if (k == ready_from - 1) begin
                    check("B_held_valid", 32'(out_valid), 32'd1);
                    check("B_held_left", 32'(out_left), 32'(fl[0]));
                    check("B_held_right", 32'(out_right), 32'(fr[0]));
                end
                if (k == abort_at) check("B_ovr_idle", 32'(out_overrun), 32'd0);
            end
            if (pid == 2 && k == 2000) begin
                check("C_abort_bclk", 32'(out_BCLK), 32'd1);
                check("C_abort_lrc", 32'(out_RECLRC), 32'd1);
                check("C_abort_mclk", 32'(out_MCLK), 32'd0);
                check("C_abort_ovr", 32'(out_overrun), 32'd0);
            end

            if (k >= 24 && ((k - 24) % 48) == 0) in_RECDAT = codec_bit((k - 24) / 48);
            ready_cur = ready_for(k + 1, ready_from, rnd);
            in_ready  = ready_cur;
            in_en     = (k + 1 < abort_at);
        end
        check({name, "_clk_mismatches"}, 32'(bad_clk), 32'd0);
        check({name, "_valid_mismatches"}, 32'(bad_valid), 32'd0);
        check({name, "_data_mismatches"}, 32'(bad_data), 32'd0);
        check({name, "_ovr_mismatches"}, 32'(bad_ov), 32'd0);
    endtask

    initial begin
        // Single pair with fixed first frame, always ready; mid-run reset afterwards.
        do_reset("init");
        randomize_frames();
        fl[0] = 24'hA5C3F1;
        fr[0] = 24'h3C0FF0;
        run_phase("A", 0, 2 * Frame + 2700, 0, 1'b0, 1 << 30);

        // Backpressure until after the overrun, then drain and drop enable.
        do_reset("midrun");
        randomize_frames();
        if (Cap == 1) run_phase("B", 1, 12510, 11000, 1'b0, 12500);
        else          run_phase("B", 1, 15530, 15500, 1'b0, 15520);

        // Abort before the first pair completes.
        do_reset("pre_abort");
        randomize_frames();
        run_phase("C", 2, 2100, 0, 1'b0, 2000);

        // Random consumer readiness over several frames.
        do_reset("pre_rand");
        randomize_frames();
        run_phase("D", 3, 3 * Frame + 2700, 0, 1'b1, 1 << 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
